// File: rtl/seg_scan_mux_pkg.sv
// Shared definitions for the seven-segment display blocks: widths, the
// all-off anode pattern and the leading-zero blanking helper.
package seg_scan_mux_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 8;

    // Common-anode banks: a high anode bit turns that digit off.
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // Returns 1 when `digit` is a leading zero that should be blanked:
    // blanking is enabled, the digit is not the rightmost one, and every
    // nibble from `digit` up to the most significant digit is zero.
    function automatic logic lz_digit_blank(
        input logic [NIBBLE_W*MAX_DIGITS-1:0] nibbles,
        input int                             num_digits,
        input int                             digit,
        input logic                           blank_en
    );
        logic all_zero;
        all_zero = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i >= digit && i < num_digits &&
                nibbles[i*NIBBLE_W +: NIBBLE_W] != '0) begin
                all_zero = 1'b0;
            end
        end
        return blank_en && (digit != 0) && all_zero;
    endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Free-running divider that emits a single-cycle tick every DIV enabled
// cycles; the count freezes while enable_i is low.
module refresh_tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        tick_o  = enable_i && (count_q == CNT_LAST);
        count_d = count_q;
        if (enable_i) begin
            count_d = tick_o ? '0 : count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for common-anode seven-segment banks with a
// load-controlled data snapshot, leading-zero blanking and decimal points.
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter  int NUM_DIGITS  = 4,
    parameter  int REFRESH_DIV = 100000,
    localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           load,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]          dp_in,
    input  logic                           blank_lz,
    output logic [NUM_DIGITS-1:0]          an,
    output logic [NIBBLE_W-1:0]            hex_num,
    output logic                           dp,
    output logic [IDX_W-1:0]               digit_idx
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                           tick;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NIBBLE_W*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]          shadow_dp_q, shadow_dp_d;
    logic [NIBBLE_W*MAX_DIGITS-1:0] data_pad;
    logic [NUM_DIGITS-1:0]          blank_mask;
    logic [NUM_DIGITS-1:0]          an_q, an_d;
    logic [NIBBLE_W-1:0]            hex_q, hex_d;
    logic                           dp_q, dp_d;

    refresh_tick_gen #(
        .DIV (REFRESH_DIV)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .enable_i (enable),
        .tick_o   (tick)
    );

    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        if (load) begin
            shadow_data_d = data;
            shadow_dp_d   = dp_in;
        end
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Widen the snapshot to the helper's fixed width; unused digits read as zero.
    always_comb begin
        data_pad = '0;
        data_pad[NIBBLE_W*NUM_DIGITS-1:0] = shadow_data_q;
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_blank
        assign blank_mask[g] = lz_digit_blank(data_pad, NUM_DIGITS, g, blank_lz);
    end

    // A blanked slot shows nothing at all, including its decimal point.
    always_comb begin
        an_d  = ANODE_OFF[NUM_DIGITS-1:0];
        hex_d = '0;
        dp_d  = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx_q == IDX_W'(d) && !blank_mask[d]) begin
                hex_d   = shadow_data_q[d*NIBBLE_W +: NIBBLE_W];
                dp_d    = shadow_dp_q[d] & enable;
                an_d[d] = ~enable;
            end
        end
    end

    // NOTE: the shadow snapshot is reset along with control state so a
    // freshly reset display shows zeros instead of stale or random data.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            an_q          <= ANODE_OFF[NUM_DIGITS-1:0];
            hex_q         <= '0;
            dp_q          <= 1'b0;
            digit_idx     <= '0;
        end else begin
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            an_q          <= an_d;
            hex_q         <= hex_d;
            dp_q          <= dp_d;
            digit_idx     <= idx_q;
        end
    end

    assign an      = an_q;
    assign hex_num = hex_q;
    assign dp      = dp_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with NUM_DIGITS=4 and REFRESH_DIV=4.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [3:0]  hex_num;
    logic        dp;
    logic [1:0]  digit_idx;

    int total = 0;
    int bad   = 0;

    // Anode pattern for each lit digit and the 16'h1234 nibble per digit.
    logic [3:0] an_lit   [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] hex_1234 [0:3] = '{4'h4, 4'h3, 4'h2, 4'h1};

    seg_scan_mux #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .data      (data),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .an        (an),
        .hex_num   (hex_num),
        .dp        (dp),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    // Reset, then load on the first enabled edge. Returns at the negedge
    // after that edge, so the next edge's outputs show digit 0 with new data.
    task automatic restart(input logic [15:0] d, input logic [3:0] p, input logic b);
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; load = 1'b0;
        @(negedge clk);
        reset = 1'b0; load = 1'b1; data = d; dp_in = p; blank_lz = b; enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; load = 1'b1; data = 16'hFFFF; dp_in = 4'hF; blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (an !== 4'b1111 || hex_num !== 4'h0 || dp !== 1'b0 || digit_idx !== 2'd0) begin
            bad++;
            $display("FAIL reset: an=%b hex=%h dp=%b idx=%0d want an=1111 hex=0 dp=0 idx=0",
                     an, hex_num, dp, digit_idx);
        end
    endtask

    task automatic test_scan();
        int d;
        restart(16'h1234, 4'b0000, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            d = ((k + 1) / 4) % 4;
            total++;
            if (an !== an_lit[d] || hex_num !== hex_1234[d] || dp !== 1'b0 || digit_idx !== 2'(d)) begin
                bad++;
                $display("FAIL scan k=%0d: an=%b hex=%h dp=%b idx=%0d want an=%b hex=%h dp=0 idx=%0d",
                         k, an, hex_num, dp, digit_idx, an_lit[d], hex_1234[d], d);
            end
        end
    endtask

    task automatic test_blank_lz();
        int d;
        logic [3:0] exp_an;
        logic [3:0] hex_0050 [0:3];
        hex_0050[0] = 4'h0; hex_0050[1] = 4'h5; hex_0050[2] = 4'h0; hex_0050[3] = 4'h0;
        restart(16'h0050, 4'b0000, 1'b1);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            d = ((k + 1) / 4) % 4;
            exp_an = (k < 16 && d >= 2) ? 4'b1111 : an_lit[d];
            total++;
            if (an !== exp_an || hex_num !== hex_0050[d] || dp !== 1'b0 || digit_idx !== 2'(d)) begin
                bad++;
                $display("FAIL blank_lz k=%0d: an=%b hex=%h idx=%0d want an=%b hex=%h idx=%0d",
                         k, an, hex_num, digit_idx, exp_an, hex_0050[d], d);
            end
            if (k == 15) blank_lz = 1'b0;
        end
    endtask

    task automatic test_zero_dp();
        int d;
        logic [3:0] exp_an;
        logic       exp_dp;
        restart(16'h0000, 4'b0100, 1'b1);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            d = ((k + 1) / 4) % 4;
            exp_an = (k < 16 && d != 0) ? 4'b1111 : an_lit[d];
            exp_dp = (k >= 16 && d == 2);
            total++;
            if (an !== exp_an || hex_num !== 4'h0 || dp !== exp_dp || digit_idx !== 2'(d)) begin
                bad++;
                $display("FAIL zero_dp k=%0d: an=%b hex=%h dp=%b want an=%b hex=0 dp=%b",
                         k, an, hex_num, dp, exp_an, exp_dp);
            end
            if (k == 15) blank_lz = 1'b0;
        end
    endtask

    task automatic test_shadow_load();
        int d;
        restart(16'h1234, 4'b0000, 1'b0);
        data = 16'hFFFF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            d = ((k + 1) / 4) % 4;
            total++;
            if (an !== an_lit[d] || hex_num !== hex_1234[d]) begin
                bad++;
                $display("FAIL no_load k=%0d: an=%b hex=%h want an=%b hex=%h",
                         k, an, hex_num, an_lit[d], hex_1234[d]);
            end
        end
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        total++;
        if (an !== 4'b1011 || hex_num !== 4'h2 || digit_idx !== 2'd2) begin
            bad++;
            $display("FAIL load_tick_edge: an=%b hex=%h idx=%0d want an=1011 hex=2 idx=2",
                     an, hex_num, digit_idx);
        end
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            total++;
            if (an !== 4'b0111 || hex_num !== 4'hF || digit_idx !== 2'd3) begin
                bad++;
                $display("FAIL load_tick_after j=%0d: an=%b hex=%h idx=%0d want an=0111 hex=f idx=3",
                         j, an, hex_num, digit_idx);
            end
        end
    endtask

    task automatic test_enable_hold();
        int d;
        restart(16'h1234, 4'b0100, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            d = ((k + 1) / 4) % 4;
            total++;
            if (an !== an_lit[d] || hex_num !== hex_1234[d] || dp !== (d == 2)) begin
                bad++;
                $display("FAIL pre_hold k=%0d: an=%b hex=%h dp=%b want an=%b hex=%h",
                         k, an, hex_num, dp, an_lit[d], hex_1234[d]);
            end
        end
        enable = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            total++;
            if (an !== 4'b1111 || hex_num !== 4'h2 || dp !== 1'b0 || digit_idx !== 2'd2) begin
                bad++;
                $display("FAIL hold j=%0d: an=%b hex=%h dp=%b idx=%0d want an=1111 hex=2 dp=0 idx=2",
                         j, an, hex_num, dp, digit_idx);
            end
        end
        enable = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            d = (j < 3) ? 2 : 3;
            total++;
            if (an !== an_lit[d] || hex_num !== hex_1234[d] || dp !== (d == 2) || digit_idx !== 2'(d)) begin
                bad++;
                $display("FAIL resume j=%0d: an=%b hex=%h dp=%b idx=%0d want an=%b hex=%h idx=%0d",
                         j, an, hex_num, dp, digit_idx, an_lit[d], hex_1234[d], d);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int d;
        restart(16'h1234, 4'b0000, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            d = ((k + 1) / 4) % 4;
            total++;
            if (an !== an_lit[d] || digit_idx !== 2'(d)) begin
                bad++;
                $display("FAIL pre_reset k=%0d: an=%b idx=%0d want an=%b idx=%0d",
                         k, an, digit_idx, an_lit[d], d);
            end
        end
        reset = 1'b1; load = 1'b1; data = 16'hFFFF; dp_in = 4'hF;
        @(negedge clk);
        total++;
        if (an !== 4'b1111 || hex_num !== 4'h0 || dp !== 1'b0 || digit_idx !== 2'd0) begin
            bad++;
            $display("FAIL mid_reset: an=%b hex=%h dp=%b idx=%0d want an=1111 hex=0 dp=0 idx=0",
                     an, hex_num, dp, digit_idx);
        end
        reset = 1'b0; load = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            d = (j < 4) ? 0 : 1;
            total++;
            if (an !== an_lit[d] || hex_num !== 4'h0 || dp !== 1'b0 || digit_idx !== 2'(d)) begin
                bad++;
                $display("FAIL post_reset j=%0d: an=%b hex=%h dp=%b idx=%0d want an=%b hex=0 dp=0 idx=%0d",
                         j, an, hex_num, dp, digit_idx, an_lit[d], d);
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; data = '0; dp_in = '0; blank_lz = 1'b0;
        test_reset();
        test_scan();
        test_blank_lz();
        test_zero_dp();
        test_shadow_load();
        test_enable_hold();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
